// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared xorshift32 constants, checker state type and step function
package prng_pkg;

    localparam int SHIFT_A   = 13;
    localparam int SHIFT_B   = 17;
    localparam int SHIFT_C   = 5;
    localparam int NUM_WORDS = 256;
    localparam int TIMEOUT   = 4096;
    localparam int CNT_W     = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    // One xorshift32 step; bits shifted past either end are discarded.
    function automatic logic [31:0] xorshift32_step(
        input logic [31:0] x,
        input int          sa = SHIFT_A,
        input int          sb = SHIFT_B,
        input int          sc = SHIFT_C
    );
        logic [31:0] x1;
        logic [31:0] x2;
        x1 = x ^ (x << sa);
        x2 = x1 ^ (x1 >> sb);
        return x2 ^ (x2 << sc);
    endfunction

endpackage

// File: rtl/xorshift32_step_comb.sv
// rtl/xorshift32_step_comb.sv - purely combinational xorshift32 next-state function
module xorshift32_step_comb
    import prng_pkg::*;
#(
    parameter int SA = SHIFT_A,
    parameter int SB = SHIFT_B,
    parameter int SC = SHIFT_C
) (
    input  logic [31:0] x,
    output logic [31:0] y
);

    assign y = xorshift32_step(x, SA, SB, SC);

endmodule

// File: rtl/rand_stream_checker.sv
// rtl/rand_stream_checker.sv - scoreboard that regenerates an xorshift32 stream and checks it
module rand_stream_checker #(
    parameter int NUM_WORDS = prng_pkg::NUM_WORDS,
    parameter int SHIFT_A   = prng_pkg::SHIFT_A,
    parameter int SHIFT_B   = prng_pkg::SHIFT_B,
    parameter int SHIFT_C   = prng_pkg::SHIFT_C,
    parameter int TIMEOUT   = prng_pkg::TIMEOUT,
    parameter int CNT_W     = prng_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [31:0]      seed,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [31:0]      first_err_data,
    output logic [31:0]      first_err_exp,
    output logic             timeout,
    output logic             overrun
);

    import prng_pkg::*;

    localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_WORDS);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    chk_state_e        state_q,          state_d;
    logic [31:0]       expected_q,       expected_d;
    logic [IDLE_W-1:0] idle_q,           idle_d;
    logic              done_q,           done_d;
    logic              pass_q,           pass_d;
    logic [CNT_W-1:0]  err_cnt_q,        err_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q,       word_cnt_d;
    logic [CNT_W-1:0]  first_err_idx_q,  first_err_idx_d;
    logic [31:0]       first_err_data_q, first_err_data_d;
    logic [31:0]       first_err_exp_q,  first_err_exp_d;
    logic              timeout_q,        timeout_d;
    logic              overrun_q,        overrun_d;

    logic [31:0] step_in;
    logic [31:0] step_out;
    logic        active;

    // A single step unit serves both the seed load and the running expectation.
    assign step_in = seed_valid ? seed : expected_q;

    xorshift32_step_comb #(
        .SA (SHIFT_A),
        .SB (SHIFT_B),
        .SC (SHIFT_C)
    ) u_step (
        .x (step_in),
        .y (step_out)
    );

    assign active = (state_q == ST_ARMED) || (state_q == ST_RUN);

    always_comb begin
        state_d          = state_q;
        expected_d       = expected_q;
        idle_d           = idle_q;
        done_d           = 1'b0;
        pass_d           = pass_q;
        err_cnt_d        = err_cnt_q;
        word_cnt_d       = word_cnt_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_data_d = first_err_data_q;
        first_err_exp_d  = first_err_exp_q;
        timeout_d        = timeout_q;
        overrun_d        = overrun_q;

        if (seed_valid) begin
            // Seed always wins; a word arriving in the same cycle is dropped.
            state_d          = ST_ARMED;
            expected_d       = step_out;
            idle_d           = '0;
            pass_d           = 1'b0;
            err_cnt_d        = '0;
            word_cnt_d       = '0;
            first_err_idx_d  = '0;
            first_err_data_d = '0;
            first_err_exp_d  = '0;
            timeout_d        = 1'b0;
            overrun_d        = 1'b0;
        end else if (active) begin
            if (in_valid) begin
                idle_d     = '0;
                word_cnt_d = word_cnt_q + 1'b1;
                expected_d = step_out;
                state_d    = ST_RUN;
                if (in_data != expected_q) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                    if (err_cnt_q == '0) begin
                        first_err_idx_d  = word_cnt_q;
                        first_err_data_d = in_data;
                        first_err_exp_d  = expected_q;
                    end
                end
                if (word_cnt_d == LAST_CNT) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0) && !timeout_q;
                end
            end else begin
                if (idle_q != IDLE_MAX) begin
                    idle_d = idle_q + 1'b1;
                end
                if (idle_d == IDLE_MAX) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                end
            end
        end else if (in_valid) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            expected_q       <= '0;
            idle_q           <= '0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            word_cnt_q       <= '0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            timeout_q        <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            expected_q       <= expected_d;
            idle_q           <= idle_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_cnt_q        <= err_cnt_d;
            word_cnt_q       <= word_cnt_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_data_q <= first_err_data_d;
            first_err_exp_q  <= first_err_exp_d;
            timeout_q        <= timeout_d;
            overrun_q        <= overrun_d;
        end
    end

    assign busy           = active;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign word_cnt       = word_cnt_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;
    assign first_err_exp  = first_err_exp_q;
    assign timeout        = timeout_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_rand_stream_checker.sv
// tb/tb_rand_stream_checker.sv - directed and randomized bench for rand_stream_checker
module tb_rand_stream_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        seed_valid = 1'b0;
    logic [31:0] seed = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        busy, done, pass, timeout, overrun;
    logic [8:0]  err_cnt, word_cnt, first_err_idx;
    logic [31:0] first_err_data, first_err_exp;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference stream state kept by the bench.
    bit [31:0] m_cur;
    int        m_words, m_err, m_fidx;
    bit [31:0] m_fdata, m_fexp;

    always #5 clk = ~clk;

    rand_stream_checker dut (
        .clk            (clk),
        .rst            (rst),
        .seed_valid     (seed_valid),
        .seed           (seed),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .word_cnt       (word_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data),
        .first_err_exp  (first_err_exp),
        .timeout        (timeout),
        .overrun        (overrun)
    );

    // Shifts written as multiply/divide by powers of two in 32-bit arithmetic.
    function automatic bit [31:0] model_next(input bit [31:0] x);
        bit [31:0] a, b;
        a = x ^ (x * 32'd8192);
        b = a ^ (a / 32'd131072);
        return b ^ (b * 32'd32);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are applied just after a falling edge and held through the next one.
    task automatic drive(input bit sv, input bit [31:0] sd, input bit iv, input bit [31:0] d);
        seed_valid = sv;
        seed       = sd;
        in_valid   = iv;
        in_data    = iv ? d : 32'h0;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic load_seed(input bit [31:0] sd);
        drive(1'b1, sd, 1'b0, 32'h0);
        m_cur = model_next(sd); m_words = 0; m_err = 0; m_fidx = 0; m_fdata = 0; m_fexp = 0;
    endtask

    task automatic send_words(input int n, input int bad_idx, input bit [31:0] bad_val,
                              input int pct, input bit gaps);
        bit [31:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
            d = m_cur;
            if (m_words == bad_idx) d = bad_val;
            else if (pct > 0 && $urandom_range(0, 99) < pct) d = m_cur ^ (32'h1 << $urandom_range(0, 31));
            if (d != m_cur) begin
                if (m_err == 0) begin m_fidx = m_words; m_fdata = d; m_fexp = m_cur; end
                m_err++;
            end
            drive(1'b0, 32'h0, 1'b1, d);
            m_cur = model_next(m_cur);
            m_words++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_words"}, word_cnt, 0);
        chk({tag, "_fidx"}, first_err_idx, 0);
        chk({tag, "_fdata"}, first_err_data, 0);
        chk({tag, "_fexp"}, first_err_exp, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int cyc;
        @(negedge clk);
        rst = 1'b1; idle_cycle(); idle_cycle(); rst = 1'b0;
        check_all_zero("reset");

        // Clean run, seed 1, with random gaps.
        load_seed(32'h1);
        chk("armed_busy", busy, 1);
        send_words(256, -1, 0, 0, 1'b1);
        chk("clean_done", done, 1);
        chk("clean_pass", pass, 1);
        chk("clean_err", err_cnt, 0);
        chk("clean_words", word_cnt, 256);
        idle_cycle();
        chk("clean_done_pulse", done, 0);
        chk("clean_busy_off", busy, 0);
        chk("clean_pass_hold", pass, 1);

        // Overrun after completion leaves the reported result alone.
        drive(1'b0, 32'h0, 1'b1, 32'h12345678);
        idle_cycle();
        chk("ovr_flag", overrun, 1);
        chk("ovr_pass", pass, 1);
        chk("ovr_words", word_cnt, 256);

        // Single corruption at index 2, back to back.
        load_seed(32'h1);
        chk("corr_ovr_clear", overrun, 0);
        send_words(256, 2, 32'h9DCCA8C4, 0, 1'b0);
        chk("corr_done", done, 1);
        chk("corr_pass", pass, 0);
        chk("corr_err", err_cnt, 1);
        chk("corr_fidx", first_err_idx, 2);
        chk("corr_fdata", first_err_data, 32'h9DCCA8C4);
        chk("corr_fexp", first_err_exp, 32'h9DCCA8C5);

        // Literal first words from seed 1, then collision at word 50.
        load_seed(32'h1);
        drive(1'b0, 0, 1'b1, 32'h00042021);
        drive(1'b0, 0, 1'b1, 32'h04080601);
        drive(1'b0, 0, 1'b1, 32'h9DCCA8C5);
        chk("lit_err", err_cnt, 0);
        chk("lit_words", word_cnt, 3);
        m_cur = model_next(model_next(model_next(model_next(32'h1))));
        m_words = 3;
        send_words(47, -1, 0, 0, 1'b1);
        chk("coll_pre_words", word_cnt, 50);
        drive(1'b1, 32'h1, 1'b1, m_cur);
        m_cur = model_next(32'h1); m_words = 0; m_err = 0;
        chk("coll_words", word_cnt, 0);
        chk("coll_err", err_cnt, 0);
        chk("coll_busy", busy, 1);
        send_words(256, -1, 0, 0, 1'b1);
        chk("coll_done", done, 1);
        chk("coll_pass", pass, 1);
        chk("coll_final_words", word_cnt, 256);

        // Timeout after 10 words.
        load_seed(32'h1);
        send_words(10, -1, 0, 0, 1'b0);
        cyc = 0;
        while (!done && cyc < 5000) begin idle_cycle(); cyc++; end
        chk("to_cycles", cyc, 4096);
        chk("to_flag", timeout, 1);
        chk("to_pass", pass, 0);
        chk("to_words", word_cnt, 10);
        chk("to_busy", busy, 0);

        // Zero seed stays zero forever.
        load_seed(32'h0);
        send_words(256, -1, 0, 0, 1'b0);
        chk("zero_done", done, 1);
        chk("zero_pass", pass, 1);

        // Random seeds with random single-bit corruptions.
        for (int r = 0; r < 3; r++) begin
            load_seed($urandom);
            send_words(256, -1, 0, 3, 1'b1);
            chk("rnd_done", done, 1);
            chk("rnd_pass", pass, (m_err == 0) ? 1 : 0);
            chk("rnd_err", err_cnt, m_err);
            chk("rnd_fidx", first_err_idx, m_fidx);
            chk("rnd_fdata", first_err_data, m_fdata);
            chk("rnd_fexp", first_err_exp, m_fexp);
        end

        // Reset mid-run discards everything; a word in IDLE is an overrun.
        load_seed(32'hCAFEF00D);
        send_words(20, 5, 32'h0, 0, 1'b0);
        rst = 1'b1; idle_cycle(); rst = 1'b0;
        check_all_zero("midrst");
        drive(1'b0, 0, 1'b1, 32'hDEADBEEF);
        chk("idle_ovr", overrun, 1);
        chk("idle_words", word_cnt, 0);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rand_stream_checker.md
Name: rand_stream_checker

Overview:
- Single-clock scoreboard in the output (clock-3) domain of the PRNG datapath.
- Consumes the out_valid/rand_num stream delivered after the FIFO read stage.
- Regenerates the expected xorshift32 sequence (shifts 13/17/5) from a loaded seed and checks every word.
- Reports pass/fail, error count, first-mismatch details, timeout and overrun.

Parameters:
- NUM_WORDS, 256, words expected per seed.
- SHIFT_A, 13, first left shift.
- SHIFT_B, 17, right shift.
- SHIFT_C, 5, second left shift.
- TIMEOUT, 4096, max idle cycles between words in RUN before abort.
- CNT_W, 9, counter width; must satisfy 2^CNT_W > NUM_WORDS.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- seed_valid  in  1  one-cycle strobe to load seed and arm the checker.
- seed  in  32  seed value, sampled when seed_valid=1.
- in_valid  in  1  stream word valid (upstream out_valid).
- in_data  in  32  stream word (upstream rand_num).
- busy  out  1  high in ARMED or RUN.
- done  out  1  one-cycle pulse on completion or abort.
- pass  out  1  sticky result: valid from done until next seed_valid.
- err_cnt  out  CNT_W  mismatching words in the current run.
- word_cnt  out  CNT_W  words consumed in the current run.
- first_err_idx  out  CNT_W  index of the first mismatch.
- first_err_data  out  32  received word at the first mismatch.
- first_err_exp  out  32  expected word at the first mismatch.
- timeout  out  1  sticky: run aborted by idle timeout.
- overrun  out  1  sticky: in_valid seen in DONE or IDLE.

Behaviour:
- Reset: every output and internal register is 0; state = IDLE.
- Reset mid-run discards all progress.
- f(x): x1=x^(x<<A); x2=x1^(x1>>B); x3=x2^(x2<<C). 32-bit, shifted-out bits discarded.
- expected register (32 b) holds the next word to compare.
- States:
  - IDLE: waits for seed_valid.
  - ARMED: seed loaded, no word received yet.
  - RUN: at least one word consumed.
  - DONE: result held.
- seed_valid in any state:
  - Next state ARMED; expected <= f(seed).
  - err_cnt, word_cnt, first_err_*, timeout, overrun, pass <= 0.
  - Idle counter cleared.
- Simultaneous seed_valid and in_valid: seed wins; the word is dropped and not counted.
- in_valid in ARMED/RUN (no seed_valid):
  - Compare in_data against expected.
  - word_cnt++; expected <= f(expected); state -> RUN.
  - On mismatch: err_cnt++. If err_cnt was 0, capture first_err_idx = old word_cnt, first_err_data and first_err_exp.
- Completion: when the accepted word is number NUM_WORDS (word_cnt becomes NUM_WORDS):
  - Next cycle: state = DONE, done=1 for exactly one cycle.
  - pass = (final err_cnt==0) && !timeout. The registered result includes the last word's comparison.
- Timeout:
  - In ARMED/RUN the idle counter increments on each cycle with in_valid=0 and clears on in_valid.
  - Reaching TIMEOUT: state -> DONE, timeout=1, done pulse, pass=0.
  - The timeout count includes ARMED, so a lost stream is caught.
- in_valid in IDLE or DONE:
  - overrun <= 1; data ignored; counters unchanged.
  - Does not alter pass already reported.
- in_data is don't-care when in_valid=0. Upstream drives 0 then; the checker does not check it.
- Saturation:
  - err_cnt and word_cnt never exceed NUM_WORDS by construction.
  - The idle counter saturates at TIMEOUT.
- busy is combinational from the state register; all other outputs are registered.

Decomposition:
- Shared package (prng_pkg):
  - Constants SHIFT_A/B/C and NUM_WORDS defaults.
  - State enum {IDLE, ARMED, RUN, DONE}.
  - Function xorshift32_step(x).
- The same function is reused by the generator stage.
- One natural sub-module, xorshift32_step_comb: pure combinational f(x), instantiated once for both the seed path and the expected path via a mux on seed_valid.
- FSM, counters and capture registers stay in the top.

Test Plan:
- Clean run:
  - Stimulus: seed_valid with seed=0x00000001, then 256 correct words. First words are 0x00042021, 0x04080601, 0x9DCCA8C5, each on a back-to-back or gapped in_valid.
  - Required response: done pulse 1 cycle after the 256th word, pass=1, err_cnt=0, word_cnt=256.
- Single corruption:
  - Stimulus: seed=1; word index 2 driven as 0x9DCCA8C4, the rest correct.
  - Required response: pass=0, err_cnt=1, first_err_idx=2, first_err_data=0x9DCCA8C4, first_err_exp=0x9DCCA8C5.
- Timeout:
  - Stimulus: seed=1, 10 correct words, then no in_valid for 4096 cycles.
  - Required response: done pulse, timeout=1, pass=0, word_cnt=10.
- Seed/data collision and restart:
  - Stimulus: mid-run (word_cnt=50), seed_valid and in_valid in the same cycle with seed=1, then 256 correct words.
  - Required response: the colliding word is dropped, counters restart from 0, pass=1.
- Overrun and reset:
  - Stimulus: after DONE, one extra in_valid; then assert rst for 1 cycle mid-run.
  - Required response: overrun=1 while pass stays at its done value; after reset all outputs are 0 and state is IDLE.
- Zero seed:
  - Stimulus: seed=0, 256 words of 0x00000000.
  - Required response: pass=1.
